// File: rtl/diff_stream_decoder_if.sv
// Serial line input and word output port bundle for diff_stream_decoder.
// slave is the decoder's view; master is the sampler/consumer side.
interface diff_stream_decoder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             in_sof;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic             out_perr;
    logic             overrun;

    modport slave (
        input  in_valid, in_bit, in_sof, out_ready,
        output out_valid, out_word, out_perr, overrun
    );

    modport master (
        output in_valid, in_bit, in_sof, out_ready,
        input  out_valid, out_word, out_perr, overrun
    );
endinterface

// File: rtl/diff_stream_decoder.sv
// Differential (running-XOR) serial decoder assembling LSB-first words into a holding register.
// Optional feature macro: DIFF_DEC_PARITY_EN appends one even-parity bit per frame and drives out_perr.
module diff_stream_decoder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    diff_stream_decoder_if.slave bus
);
`ifdef DIFF_DEC_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned FRAME = WIDTH + PAR_BITS;
    localparam int unsigned CNT_W = $clog2(FRAME + 1);

    localparam logic [0:0] S_HUNT    = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_word_q, out_word_d;
    logic             overrun_q, overrun_d;
    logic             dbit_c;
    logic             done_c;
`ifdef DIFF_DEC_PARITY_EN
    logic             par_q, par_d;
    logic             out_perr_q, out_perr_d;
`endif

    // Next-state, bit assembly and holding-register control
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        overrun_d   = overrun_q;
        done_c      = 1'b0;
        dbit_c      = bus.in_bit ^ prev_q;
`ifdef DIFF_DEC_PARITY_EN
        par_d       = par_q;
        out_perr_d  = out_perr_q;
`endif

        if (bus.in_valid) begin
            prev_d = bus.in_bit;
            if (bus.in_sof) begin
                shreg_d = WIDTH'(dbit_c);
                cnt_d   = CNT_W'(1);
                state_d = S_COLLECT;
`ifdef DIFF_DEC_PARITY_EN
                par_d   = dbit_c;
`endif
            end else if (state_q == S_COLLECT) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CNT_W'(i)) shreg_d[i] = dbit_c;
                end
`ifdef DIFF_DEC_PARITY_EN
                par_d = par_q ^ dbit_c;
`endif
                if (cnt_q == CNT_W'(FRAME - 1)) begin
                    done_c = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // A completed word may replace the held one only if it is being consumed now
        if (done_c) begin
            if (!out_valid_q || bus.out_ready) begin
                out_valid_d = 1'b1;
                out_word_d  = shreg_d;
`ifdef DIFF_DEC_PARITY_EN
                out_perr_d  = par_d;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HUNT;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            overrun_q   <= 1'b0;
`ifdef DIFF_DEC_PARITY_EN
            par_q       <= 1'b0;
            out_perr_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            overrun_q   <= overrun_d;
`ifdef DIFF_DEC_PARITY_EN
            par_q       <= par_d;
            out_perr_q  <= out_perr_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.overrun   = overrun_q;
`ifdef DIFF_DEC_PARITY_EN
    assign bus.out_perr  = out_perr_q;
`else
    assign bus.out_perr  = 1'b0;
`endif
endmodule

// File: tb/tb_diff_stream_decoder.sv
// Self-checking bench for diff_stream_decoder: queue-based frame model plus directed literal checks.
module tb_diff_stream_decoder;
    localparam int unsigned W = 8;
`ifdef DIFF_DEC_PARITY_EN
    localparam int unsigned FRAME = W + 1;
`else
    localparam int unsigned FRAME = W;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    diff_stream_decoder_if #(.WIDTH(W)) bus ();

    diff_stream_decoder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;
    logic tb_line;

    // Reference model: decoded bits collected in a queue, word built when the frame is full
    bit           m_prev;
    bit           m_hunt;
    bit           m_q[$];
    bit           m_valid;
    logic [W-1:0] m_word;
    bit           m_perr;
    bit           m_ovr;

    always @(posedge clk) begin : model_blk
        bit           d;
        bit           done;
        logic [W-1:0] w;
        bit           p;
        if (rst) begin
            m_prev = 0; m_hunt = 1; m_q.delete();
            m_valid = 0; m_word = '0; m_perr = 0; m_ovr = 0;
        end else begin
            done = 0; w = '0; p = 0;
            if (bus.in_valid) begin
                d = bus.in_bit ^ m_prev;
                m_prev = bus.in_bit;
                if (bus.in_sof) begin
                    m_q.delete();
                    m_q.push_back(d);
                    m_hunt = 0;
                end else if (!m_hunt) begin
                    m_q.push_back(d);
                end
                if (!m_hunt && m_q.size() == FRAME) begin
                    for (int i = 0; i < int'(W); i++) w[i] = m_q[i];
`ifdef DIFF_DEC_PARITY_EN
                    for (int i = 0; i < int'(FRAME); i++) p = p ^ m_q[i];
`endif
                    m_q.delete();
                    done = 1;
                end
            end
            if (done) begin
                if (!m_valid || bus.out_ready) begin
                    m_valid = 1; m_word = w; m_perr = p;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && bus.out_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("model overrun", 32'(bus.overrun), 32'(m_ovr));
            if (m_valid) begin
                chk("model out_word", 32'(bus.out_word), 32'(m_word));
                chk("model out_perr", 32'(bus.out_perr), 32'(m_perr));
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic s, input logic r);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_bit    = b;
        bus.in_sof    = s;
        bus.out_ready = r;
    endtask

    task automatic send_raw(input logic e, input logic s, input logic r);
        tb_line = e;
        drive(1'b1, e, s, r);
    endtask

    task automatic send_bit(input logic d, input logic s, input logic r);
        send_raw(d ^ tb_line, s, r);
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, r);
    endtask

    task automatic send_word(input logic [W-1:0] data, input bit sof, input bit r,
                             input bit r_last, input bit bad_par, input bit gaps);
        for (int i = 0; i < int'(W); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle(1, r);
            send_bit(data[i], sof && (i == 0), (i == int'(FRAME) - 1) ? r_last : r);
        end
`ifdef DIFF_DEC_PARITY_EN
        send_bit((^data) ^ bad_par, 1'b0, r_last);
`else
        if (bad_par) idle(0, r);
`endif
    endtask

    task automatic finish_frame();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tb_line = 1'b0;
    endtask

    task automatic send_e_list(input logic [7:0] e, input logic r);
        for (int i = 0; i < 8; i++) send_raw(e[i], i == 0, r);
    endtask

    initial begin
        logic [7:0] e_a5;
        e_a5 = 8'b0110_0011;   // line e = 1,1,0,0,0,1,1,0 (bit 0 first)
        rst = 1'b1;
        tb_line = 1'b0;
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_sof = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_word", 32'(bus.out_word), 32'd0);
        chk("reset out_perr", 32'(bus.out_perr), 32'd0);
        chk("reset overrun", 32'(bus.overrun), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame decodes to 0xA5
        send_e_list(e_a5, 1'b1);
`ifdef DIFF_DEC_PARITY_EN
        send_raw(1'b0, 1'b0, 1'b1);
`endif
        finish_frame();
        chk("a5 out_valid", 32'(bus.out_valid), 32'd1);
        chk("a5 out_word", 32'(bus.out_word), 32'hA5);
        chk("a5 overrun", 32'(bus.overrun), 32'd0);
        chk("a5 out_perr", 32'(bus.out_perr), 32'd0);
        idle(2, 1'b1);

        // Garbage before sof leaves prev=1, so the same line bits decode to 0xA4
        do_reset();
        send_raw(1'b1, 1'b0, 1'b1);
        send_raw(1'b0, 1'b0, 1'b1);
        send_raw(1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        @(posedge clk); #1;
        chk("hunt no output", 32'(bus.out_valid), 32'd0);
        send_e_list(e_a5, 1'b1);
`ifdef DIFF_DEC_PARITY_EN
        send_raw(1'b1, 1'b0, 1'b1);
`endif
        finish_frame();
        chk("prev cont out_valid", 32'(bus.out_valid), 32'd1);
        chk("prev cont out_word", 32'(bus.out_word), 32'hA4);
        idle(2, 1'b1);

        // Back-to-back frames while stalled: second dropped, overrun sticks
        do_reset();
        send_word(8'h3C, 1, 0, 0, 0, 0);
        send_word(8'h5A, 0, 0, 0, 0, 0);
        finish_frame();
        chk("ovr held word", 32'(bus.out_word), 32'h3C);
        chk("ovr set", 32'(bus.overrun), 32'd1);
        idle(3, 1'b0);
        chk("ovr sticky", 32'(bus.overrun), 32'd1);
        do_reset();
        @(posedge clk); #1;
        chk("ovr cleared by rst", 32'(bus.overrun), 32'd0);
        send_word(8'h3C, 1, 0, 0, 0, 0);
        send_word(8'h5A, 0, 0, 1, 0, 0);
        finish_frame();
        chk("ready load word", 32'(bus.out_word), 32'h5A);
        chk("ready load overrun", 32'(bus.overrun), 32'd0);
        idle(2, 1'b1);

        // sof at bit 5 restarts the word
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), i == 0, 1'b1);
        idle(1, 1'b1);
        @(posedge clk); #1;
        chk("partial no output", 32'(bus.out_valid), 32'd0);
        send_word(8'hC3, 1, 1, 1, 0, 0);
        finish_frame();
        chk("resync out_word", 32'(bus.out_word), 32'hC3);
        chk("resync out_valid", 32'(bus.out_valid), 32'd1);
        idle(2, 1'b1);

`ifdef DIFF_DEC_PARITY_EN
        send_word(8'hA5, 1, 1, 1, 0, 0);
        finish_frame();
        chk("par good perr", 32'(bus.out_perr), 32'd0);
        idle(1, 1'b1);
        send_word(8'hA5, 1, 1, 1, 1, 0);
        finish_frame();
        chk("par bad perr", 32'(bus.out_perr), 32'd1);
        chk("par bad word", 32'(bus.out_word), 32'hA5);
        idle(2, 1'b1);
`endif

        // Reset mid-frame while holding a word; rst wins over an sof bit
        send_word(8'h96, 1, 0, 0, 0, 0);
        finish_frame();
        chk("pre-rst out_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_sof = 1'b1; bus.in_bit = 1'b1;
        @(posedge clk); #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_word", 32'(bus.out_word), 32'd0);
        chk("rst out_perr", 32'(bus.out_perr), 32'd0);
        chk("rst overrun", 32'(bus.overrun), 32'd0);
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0; bus.in_sof = 1'b0;
        tb_line = 1'b0;
        send_e_list(e_a5, 1'b1);
`ifdef DIFF_DEC_PARITY_EN
        send_raw(1'b0, 1'b0, 1'b1);
`endif
        finish_frame();
        chk("post-rst out_word", 32'(bus.out_word), 32'hA5);
        idle(2, 1'b1);

        // Mixed traffic with gaps, random ready and occasional resync
        for (int k = 0; k < 40; k++) begin
            send_word(W'($urandom), bit'($urandom_range(0, 3) == 0),
                      bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 4) == 0) idle(2, 1'b1);
        end
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
